// File: rtl/gng_stats_if.sv
// Handshake and result bundle between the gng sample stream, its controller
// and the gng_stats window statistics block.
interface gng_stats_if #(
    parameter int LOG2_N = 16,
    parameter int DW     = 16
);
    logic                       start;
    logic                       ce;
    logic                       valid_in;
    logic [DW-1:0]              data_in;
    logic                       busy;
    logic                       done;
    logic [DW+LOG2_N-1:0]       sum_out;
    logic [2*DW-2+LOG2_N:0]     sumsq_out;
    logic [DW-1:0]              mean_out;
    logic [2*DW-2:0]            msq_out;
    logic [DW-1:0]              max_abs_out;

    modport slave (
        input  start, valid_in, data_in,
        output ce, busy, done, sum_out, sumsq_out, mean_out, msq_out, max_abs_out
    );

    modport master (
        output start, valid_in, data_in,
        input  ce, busy, done, sum_out, sumsq_out, mean_out, msq_out, max_abs_out
    );
endinterface

// File: rtl/gng_stats.sv
// Window statistics over 2**LOG2_N accepted gng samples: sum, sum of squares,
// mean, mean square and peak magnitude, with a 3-stage accumulate pipeline.
//
// state   | meaning
// S_IDLE  | waiting for start; results from last window held
// S_FILL  | ce high, accepting samples until the window is full
// S_DRAIN | ce low, 3 cycles to flush the S1..S3 pipeline
// S_DONE  | one cycle, results registered, done high
module gng_stats #(
    parameter int LOG2_N = 16,
    parameter int DW     = 16
) (
    input  logic        clk,
    input  logic        rstn,
    gng_stats_if.slave  bus
);
    localparam int SW = DW + LOG2_N;
    localparam int MW = 2*DW - 1;
    localparam int QW = MW + LOG2_N;
    localparam logic [LOG2_N:0] LAST_IDX = (LOG2_N+1)'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_ce;
    logic                   r_busy;
    logic                   r_done;
    logic [LOG2_N:0]        r_cnt;
    logic [1:0]             r_drain;

    logic                   r_s1_v;
    logic signed [DW-1:0]   r_s1_x;
    logic                   r_s2_v;
    logic signed [DW-1:0]   r_s2_x;
    logic [MW-1:0]          r_s2_sq;
    logic [DW-1:0]          r_s2_abs;

    logic signed [SW-1:0]   r_sum;
    logic [QW-1:0]          r_sumsq;
    logic [DW-1:0]          r_max;

    logic [SW-1:0]          r_sum_out;
    logic [QW-1:0]          r_sumsq_out;
    logic [DW-1:0]          r_mean_out;
    logic [MW-1:0]          r_msq_out;
    logic [DW-1:0]          r_max_out;

    logic                   w_acc;
    logic [MW-1:0]          w_sq;
    logic [DW-1:0]          w_abs;

    assign w_acc = r_ce && bus.valid_in;
    // (-2**(DW-1))**2 = 2**(2DW-2) still fits the MW-bit unsigned square
    assign w_sq  = MW'(r_s1_x * r_s1_x);
    assign w_abs = r_s1_x[DW-1] ? (~r_s1_x + DW'(1)) : r_s1_x;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_ce        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_s1_v      <= 1'b0;
            r_s1_x      <= '0;
            r_s2_v      <= 1'b0;
            r_s2_x      <= '0;
            r_s2_sq     <= '0;
            r_s2_abs    <= '0;
            r_sum       <= '0;
            r_sumsq     <= '0;
            r_max       <= '0;
            r_sum_out   <= '0;
            r_sumsq_out <= '0;
            r_mean_out  <= '0;
            r_msq_out   <= '0;
            r_max_out   <= '0;
        end else begin
            r_s1_v <= w_acc;
            if (w_acc) r_s1_x <= bus.data_in;
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_x   <= r_s1_x;
                r_s2_sq  <= w_sq;
                r_s2_abs <= w_abs;
            end
            if (r_s2_v) begin
                r_sum   <= r_sum + SW'(r_s2_x);
                r_sumsq <= r_sumsq + QW'(r_s2_sq);
                if (r_s2_abs > r_max) r_max <= r_s2_abs;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_FILL;
                        r_ce        <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_s1_v      <= 1'b0;
                        r_s2_v      <= 1'b0;
                        r_sum       <= '0;
                        r_sumsq     <= '0;
                        r_max       <= '0;
                        r_sum_out   <= '0;
                        r_sumsq_out <= '0;
                        r_mean_out  <= '0;
                        r_msq_out   <= '0;
                        r_max_out   <= '0;
                    end
                end
                S_FILL: begin
                    if (w_acc) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_DRAIN;
                            r_ce    <= 1'b0;
                            r_drain <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 1'b1;
                    if (r_drain == 2'd2) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_sum_out   <= r_sum;
                        r_sumsq_out <= r_sumsq;
                        r_mean_out  <= r_sum[SW-1:LOG2_N];
                        r_msq_out   <= r_sumsq[QW-1:LOG2_N];
                        r_max_out   <= r_max;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ce          = r_ce;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.sum_out     = r_sum_out;
    assign bus.sumsq_out   = r_sumsq_out;
    assign bus.mean_out    = r_mean_out;
    assign bus.msq_out     = r_msq_out;
    assign bus.max_abs_out = r_max_out;
endmodule

// File: tb/tb_gng_stats.sv
// Self-checking bench for gng_stats at LOG2_N=2: directed vector table,
// reset/ignored-start corner cases and randomized windows against a model.
module tb_gng_stats;
    localparam int LOG2_N = 2;
    localparam int DW     = 16;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    logic [15:0] acc [4];
    int          fill_cyc;
    int          naccepted;

    gng_stats_if #(.LOG2_N(LOG2_N), .DW(DW)) bus ();
    gng_stats #(.LOG2_N(LOG2_N), .DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] smp;
        int          vmode;
        bit          noise;
        longint      e_sum;
        longint      e_sumsq;
        logic [15:0] e_mean;
        longint      e_msq;
        logic [15:0] e_max;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_results(input longint e_sum, input longint e_sumsq,
                                 input logic [15:0] e_mean, input longint e_msq,
                                 input logic [15:0] e_max);
        chk("sum_out",     64'(bus.sum_out),     e_sum & 64'h3FFFF);
        chk("sumsq_out",   64'(bus.sumsq_out),   e_sumsq & 64'h1_FFFF_FFFF);
        chk("mean_out",    64'(bus.mean_out),    64'(e_mean));
        chk("msq_out",     64'(bus.msq_out),     e_msq & 64'h7FFF_FFFF);
        chk("max_abs_out", 64'(bus.max_abs_out), 64'(e_max));
    endtask

    // Runs one window; returns at the negedge of the DONE cycle (or after timeout).
    task automatic run_window(input logic [63:0] smp, input int vmode, input bit noise);
        int  idx = 0;
        int  cyc = 0;
        int  to  = 0;
        bit  v;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        if (!noise) bus.start = 1'b0;
        while (idx < 4 && cyc < 200) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.valid_in = v;
            bus.data_in  = smp[idx*16 +: 16];
            if (bus.ce && v) begin
                acc[idx] = smp[idx*16 +: 16];
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        fill_cyc  = cyc;
        naccepted = idx;
        chk("fill_accepts", 64'(idx), 64'd4);
        chk("ce_low_after_last", 64'(bus.ce), 64'd0);
        bus.valid_in = 1'b1;
        bus.data_in  = 16'h7FFF;
        while (!bus.done && to < 10) begin
            @(negedge clk);
            to++;
        end
        chk("done_seen", 64'(bus.done), 64'd1);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic finish_window();
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        longint       m_sum, m_sq, s, m_max;
        logic [63:0]  rs;
        int           guard;
        checks   = 0;
        failures = 0;
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        rstn = 1'b0;

        vt[0] = '{64'h0800_0800_0800_0800, 0, 1'b0, 64'sd8192,    64'sd16777216,   16'h0800, 64'sd4194304,    16'h0800};
        vt[1] = '{64'h0800_F800_0800_F800, 0, 1'b0, 64'sd0,       64'sd16777216,   16'h0000, 64'sd4194304,    16'h0800};
        vt[2] = '{64'h8000_8000_8000_8000, 0, 1'b1, -64'sd131072, 64'sd4294967296, 16'h8000, 64'sd1073741824, 16'h8000};
        vt[3] = '{64'h0400_0400_0400_0400, 1, 1'b0, 64'sd4096,    64'sd4194304,    16'h0400, 64'sd1048576,    16'h0400};
        vt[4] = '{64'hFFFE_0000_FFFF_0001, 0, 1'b1, -64'sd2,      64'sd6,          16'hFFFF, 64'sd1,          16'h0002};

        repeat (3) @(negedge clk);
        chk("rst_ce",   64'(bus.ce),   64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        check_results(0, 0, 16'h0000, 0, 16'h0000);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_window(vt[i].smp, vt[i].vmode, vt[i].noise);
            check_results(vt[i].e_sum, vt[i].e_sumsq, vt[i].e_mean, vt[i].e_msq, vt[i].e_max);
            if (vt[i].vmode == 1) chk("toggle_fill_ge7", 64'(fill_cyc >= 7), 64'd1);
            finish_window();
        end

        // Abort a window with reset after two accepts.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = 16'h1000;
        naccepted = 0;
        guard     = 0;
        while (naccepted < 2 && guard < 20) begin
            if (bus.ce) naccepted++;
            guard++;
            @(negedge clk);
        end
        chk("pre_abort_ce", 64'(bus.ce), 64'd1);
        rstn = 1'b0;
        #1;
        chk("abort_ce",   64'(bus.ce),   64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        check_results(0, 0, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        rstn = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("abort_idle_ce", 64'(bus.ce), 64'd0);
        run_window(vt[0].smp, 0, 1'b0);
        check_results(vt[0].e_sum, vt[0].e_sumsq, vt[0].e_mean, vt[0].e_msq, vt[0].e_max);
        finish_window();

        // Randomized windows against a model built from the accepted samples.
        for (int w = 0; w < 15; w++) begin
            rs = {$urandom, $urandom};
            if (w == 0) rs[15:0] = 16'h8000;
            if (w == 1) rs[31:16] = 16'h7FFF;
            run_window(rs, 2, w[0]);
            m_sum = 0;
            m_sq  = 0;
            m_max = 0;
            for (int k = 0; k < 4; k++) begin
                s = longint'($signed(acc[k]));
                m_sum += s;
                m_sq  += s * s;
                if ((s < 0 ? -s : s) > m_max) m_max = (s < 0 ? -s : s);
            end
            check_results(m_sum, m_sq, 16'((m_sum >>> LOG2_N) & 64'hFFFF),
                          m_sq >> LOG2_N, 16'(m_max));
            finish_window();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
